// File: rtl/comp_dispatch_collect.sv
// Order-preserving dispatcher/collector for an array of compression cores.
// Packets go round-robin to eligible cores; outputs are re-serialised via an order FIFO of core IDs.
//   state   | meaning
//   IN_IDLE | waiting for a first beat; target chosen from eligible cores
//   IN_PKT  | mid-packet; beats routed to the locked core
module comp_dispatch_collect #(
  parameter int N_CORES      = 4,
  parameter int DATA_BITS    = 512,
  parameter int MAX_INFLIGHT = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [DATA_BITS-1:0]           s_tdata,
  input  logic [DATA_BITS/8-1:0]         s_tkeep,
  input  logic                           s_tlast,
  input  logic                           s_tvalid,
  output logic                           s_tready,
  output logic [N_CORES*DATA_BITS-1:0]   c_in_tdata,
  output logic [N_CORES*DATA_BITS/8-1:0] c_in_tkeep,
  output logic [N_CORES-1:0]             c_in_tlast,
  output logic [N_CORES-1:0]             c_in_tvalid,
  input  logic [N_CORES-1:0]             c_in_tready,
  input  logic [N_CORES*DATA_BITS-1:0]   c_out_tdata,
  input  logic [N_CORES*DATA_BITS/8-1:0] c_out_tkeep,
  input  logic [N_CORES-1:0]             c_out_tlast,
  input  logic [N_CORES-1:0]             c_out_tvalid,
  output logic [N_CORES-1:0]             c_out_tready,
  output logic [DATA_BITS-1:0]           m_tdata,
  output logic [DATA_BITS/8-1:0]         m_tkeep,
  output logic                           m_tlast,
  output logic                           m_tvalid,
  input  logic                           m_tready,
  input  logic [N_CORES-1:0]             core_en,
  output logic [31:0]                    stat_pkts_in,
  output logic [31:0]                    stat_pkts_out,
  output logic                           busy
);
  localparam int KB          = DATA_BITS / 8;
  localparam int ORDER_DEPTH = N_CORES * MAX_INFLIGHT;
  localparam int IDW         = (N_CORES > 1) ? $clog2(N_CORES) : 1;
  localparam int IFW         = $clog2(MAX_INFLIGHT + 1);
  localparam int PW          = (ORDER_DEPTH > 1) ? $clog2(ORDER_DEPTH) : 1;
  localparam int CW          = $clog2(ORDER_DEPTH + 1);

  typedef enum logic {IN_IDLE, IN_PKT} in_state_t;

  in_state_t      state;
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] lock_id;
  logic [IDW-1:0] sel;
  logic [IDW-1:0] route_id;
  logic [IDW-1:0] head;
  logic [IFW-1:0] inflight [N_CORES];
  logic [IDW-1:0] order_mem [ORDER_DEPTH];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic [CW-1:0]  order_cnt;
  logic [N_CORES-1:0] eligible;
  logic found;
  logic route_ok;
  logic out_ok;
  logic in_hs;
  logic first_hs;
  logic pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(ORDER_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    for (int i = 0; i < N_CORES; i++)
      eligible[i] = core_en[i] && (inflight[i] < IFW'(MAX_INFLIGHT));
  end

  // Round-robin scan starting at rr_ptr, wrapping modulo N_CORES.
  always_comb begin
    int j;
    j     = 0;
    sel   = '0;
    found = 1'b0;
    for (int k = 0; k < N_CORES; k++) begin
      j = int'(rr_ptr) + k;
      if (j >= N_CORES) j = j - N_CORES;
      if (!found && eligible[j]) begin
        sel   = IDW'(j);
        found = 1'b1;
      end
    end
  end

  // Outputs are held at their idle values while rst_n is low.
  assign route_id = (state == IN_PKT) ? lock_id : sel;
  assign route_ok = rst_n && ((state == IN_PKT) || found);

  always_comb begin
    s_tready    = 1'b0;
    c_in_tvalid = '0;
    for (int i = 0; i < N_CORES; i++) begin
      if (route_ok && (route_id == IDW'(i))) begin
        c_in_tvalid[i] = s_tvalid;
        s_tready       = c_in_tready[i];
      end
    end
  end

  assign c_in_tdata = {N_CORES{s_tdata}};
  assign c_in_tkeep = {N_CORES{s_tkeep}};
  assign c_in_tlast = {N_CORES{s_tlast}};

  assign in_hs    = s_tvalid && s_tready;
  assign first_hs = in_hs && (state == IN_IDLE);

  assign head   = order_mem[rd_ptr];
  assign out_ok = rst_n && (order_cnt != '0);

  always_comb begin
    m_tdata      = '0;
    m_tkeep      = '0;
    m_tlast      = 1'b0;
    m_tvalid     = 1'b0;
    c_out_tready = '0;
    for (int i = 0; i < N_CORES; i++) begin
      if (head == IDW'(i)) begin
        m_tdata         = c_out_tdata[i*DATA_BITS +: DATA_BITS];
        m_tkeep         = c_out_tkeep[i*KB +: KB];
        m_tlast         = c_out_tlast[i];
        m_tvalid        = out_ok && c_out_tvalid[i];
        c_out_tready[i] = out_ok && m_tready;
      end
    end
  end

  assign pop  = m_tvalid && m_tready && m_tlast;
  assign busy = rst_n && ((state == IN_PKT) || (order_cnt != '0));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IN_IDLE;
      rr_ptr        <= '0;
      lock_id       <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      order_cnt     <= '0;
      stat_pkts_in  <= '0;
      stat_pkts_out <= '0;
      for (int i = 0; i < N_CORES; i++) inflight[i] <= '0;
    end else begin
      if (first_hs) begin
        order_mem[wr_ptr] <= sel;
        wr_ptr            <= ptr_inc(wr_ptr);
        rr_ptr            <= (sel == IDW'(N_CORES - 1)) ? '0 : sel + 1'b1;
        lock_id           <= sel;
        stat_pkts_in      <= stat_pkts_in + 32'd1;
        if (!s_tlast) state <= IN_PKT;
      end
      if ((state == IN_PKT) && in_hs && s_tlast) state <= IN_IDLE;

      if (pop) begin
        rd_ptr        <= ptr_inc(rd_ptr);
        stat_pkts_out <= stat_pkts_out + 32'd1;
      end
      if (first_hs && !pop) order_cnt <= order_cnt + 1'b1;
      else if (pop && !first_hs) order_cnt <= order_cnt - 1'b1;

      // A push and a pop on the same core in one cycle cancel out.
      for (int i = 0; i < N_CORES; i++) begin
        if ((first_hs && (sel == IDW'(i))) && !(pop && (head == IDW'(i))))
          inflight[i] <= inflight[i] + 1'b1;
        else if ((pop && (head == IDW'(i))) && !(first_hs && (sel == IDW'(i))))
          inflight[i] <= inflight[i] - 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_comp_dispatch_collect.sv
// Directed bench for comp_dispatch_collect: pass-through core models plus input/output logs.
// Packet words encode packet id and beat number so order and integrity can be checked.
module tb_comp_dispatch_collect;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int KB = DW / 8;
  localparam int MI = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [DW-1:0]   s_tdata = '0;
  logic [KB-1:0]   s_tkeep = '0;
  logic            s_tlast = 1'b0;
  logic            s_tvalid = 1'b0;
  logic            s_tready;
  logic [N*DW-1:0] c_in_tdata;
  logic [N*KB-1:0] c_in_tkeep;
  logic [N-1:0]    c_in_tlast;
  logic [N-1:0]    c_in_tvalid;
  logic [N-1:0]    c_in_tready = '1;
  logic [N*DW-1:0] c_out_tdata;
  logic [N*KB-1:0] c_out_tkeep;
  logic [N-1:0]    c_out_tlast;
  logic [N-1:0]    c_out_tvalid;
  logic [N-1:0]    c_out_tready;
  logic [DW-1:0]   m_tdata;
  logic [KB-1:0]   m_tkeep;
  logic            m_tlast;
  logic            m_tvalid;
  logic            m_tready = 1'b1;
  logic [N-1:0]    core_en = '1;
  logic [31:0]     stat_pkts_in;
  logic [31:0]     stat_pkts_out;
  logic            busy;
  logic [N-1:0]    core_out_en = '1;

  int vectors = 0;
  int errors  = 0;

  comp_dispatch_collect #(.N_CORES(N), .DATA_BITS(DW), .MAX_INFLIGHT(MI)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tlast(s_tlast), .s_tvalid(s_tvalid), .s_tready(s_tready),
    .c_in_tdata(c_in_tdata), .c_in_tkeep(c_in_tkeep), .c_in_tlast(c_in_tlast),
    .c_in_tvalid(c_in_tvalid), .c_in_tready(c_in_tready),
    .c_out_tdata(c_out_tdata), .c_out_tkeep(c_out_tkeep), .c_out_tlast(c_out_tlast),
    .c_out_tvalid(c_out_tvalid), .c_out_tready(c_out_tready),
    .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tlast(m_tlast), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .core_en(core_en), .stat_pkts_in(stat_pkts_in), .stat_pkts_out(stat_pkts_out), .busy(busy)
  );

  // Core models: identity FIFOs of {last, keep, data}, output gated by core_out_en.
  logic [DW+KB:0] cmem [N][32];
  logic [4:0]     cwr [N];
  logic [4:0]     crd [N];
  logic [DW+KB:0] cw;

  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (!rst_n) begin
        cwr[i] <= '0;
        crd[i] <= '0;
      end else begin
        if (c_in_tvalid[i] && c_in_tready[i]) begin
          cmem[i][cwr[i]] <= {c_in_tlast[i], c_in_tkeep[i*KB +: KB], c_in_tdata[i*DW +: DW]};
          cwr[i] <= cwr[i] + 5'd1;
        end
        if (c_out_tvalid[i] && c_out_tready[i]) crd[i] <= crd[i] + 5'd1;
      end
    end
  end

  always_comb begin
    cw = '0;
    c_out_tdata = '0;
    c_out_tkeep = '0;
    c_out_tlast = '0;
    c_out_tvalid = '0;
    for (int i = 0; i < N; i++) begin
      cw = cmem[i][crd[i]];
      c_out_tdata[i*DW +: DW] = cw[DW-1:0];
      c_out_tkeep[i*KB +: KB] = cw[DW+KB-1:DW];
      c_out_tlast[i]          = cw[DW+KB];
      c_out_tvalid[i]         = (cwr[i] != crd[i]) && core_out_en[i];
    end
  end

  // Logs: which core took each packet's first beat, and every emitted output beat.
  int             core_log [64];
  int             in_cnt;
  bit             in_first;
  int             in_beats [N];
  logic [DW+KB:0] out_log [64];
  int             out_cnt;

  always @(posedge clk) begin
    if (!rst_n) begin
      in_cnt   <= 0;
      in_first <= 1'b1;
      out_cnt  <= 0;
      for (int i = 0; i < N; i++) in_beats[i] <= 0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (c_in_tvalid[i] && c_in_tready[i]) begin
          in_beats[i] <= in_beats[i] + 1;
          if (in_first && in_cnt < 64) begin
            core_log[in_cnt] <= i;
            in_cnt <= in_cnt + 1;
          end
          in_first <= c_in_tlast[i];
        end
      end
      if (m_tvalid && m_tready && out_cnt < 64) begin
        out_log[out_cnt] <= {m_tlast, m_tkeep, m_tdata};
        out_cnt <= out_cnt + 1;
      end
    end
  end

  function automatic logic [DW+KB:0] exp_word(input int pkt, input int b, input int n);
    logic [DW-1:0] d;
    d = 32'hD000_0000 + DW'(pkt * 256 + b);
    return {(b == n - 1), ((b == n - 1) ? 4'h3 : 4'hF), d};
  endfunction

  task automatic drive_beat(input int pkt, input int b, input int n);
    logic [DW+KB:0] x;
    x = exp_word(pkt, b, n);
    s_tdata  = x[DW-1:0];
    s_tkeep  = x[DW+KB-1:DW];
    s_tlast  = x[DW+KB];
    s_tvalid = 1'b1;
  endtask

  task automatic send_pkt(input int pkt, input int n);
    int w;
    for (int b = 0; b < n; b++) begin
      drive_beat(pkt, b, n);
      w = 0;
      while (!s_tready && w < 500) begin
        @(negedge clk);
        w++;
      end
      vectors++;
      if (s_tready !== 1'b1) begin
        errors++;
        $display("FAIL send_timeout pkt %0d beat %0d: s_tready got %b want 1", pkt, b, s_tready);
        s_tvalid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    s_tvalid = 1'b0;
  endtask

  task automatic wait_out(input int n);
    int w;
    w = 0;
    while (out_cnt < n && w < 2000) begin
      @(negedge clk);
      w++;
    end
    vectors++;
    if (out_cnt < n) begin
      errors++;
      $display("FAIL out_timeout: out beats got %0d want %0d", out_cnt, n);
    end
  endtask

  task automatic do_reset();
    s_tvalid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    core_en = '1; c_in_tready = '1; m_tready = 1'b1; core_out_en = '1;
    drive_beat(0, 0, 1);
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    vectors++; if (s_tready !== 1'b0) begin errors++; $display("FAIL rst_s_tready: got %b want 0", s_tready); end
    vectors++; if (c_in_tvalid !== 4'b0000) begin errors++; $display("FAIL rst_c_in_tvalid: got %b want 0000", c_in_tvalid); end
    vectors++; if (c_out_tready !== 4'b0000) begin errors++; $display("FAIL rst_c_out_tready: got %b want 0000", c_out_tready); end
    vectors++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL rst_m_tvalid: got %b want 0", m_tvalid); end
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
    vectors++; if (stat_pkts_in !== 32'd0) begin errors++; $display("FAIL rst_stat_in: got %0d want 0", stat_pkts_in); end
    vectors++; if (stat_pkts_out !== 32'd0) begin errors++; $display("FAIL rst_stat_out: got %0d want 0", stat_pkts_out); end
    s_tvalid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    vectors++; if (s_tready !== 1'b1) begin errors++; $display("FAIL idle_s_tready: got %b want 1", s_tready); end
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int p = 0; p < 8; p++) send_pkt(p, 3);
    wait_out(24);
    repeat (5) @(negedge clk);
    for (int p = 0; p < 8; p++) begin
      vectors++; if (core_log[p] !== p % 4) begin errors++; $display("FAIL t1_core pkt %0d: got %0d want %0d", p, core_log[p], p % 4); end
    end
    for (int k = 0; k < 24; k++) begin
      vectors++; if (out_log[k] !== exp_word(k / 3, k % 3, 3)) begin errors++; $display("FAIL t1_out beat %0d: got %h want %h", k, out_log[k], exp_word(k / 3, k % 3, 3)); end
    end
    vectors++; if (out_cnt !== 24) begin errors++; $display("FAIL t1_out_cnt: got %0d want 24", out_cnt); end
    vectors++; if (stat_pkts_in !== 32'd8) begin errors++; $display("FAIL t1_stat_in: got %0d want 8", stat_pkts_in); end
    vectors++; if (stat_pkts_out !== 32'd8) begin errors++; $display("FAIL t1_stat_out: got %0d want 8", stat_pkts_out); end
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL t1_busy: got %b want 0", busy); end
  endtask

  task automatic test_head_blocking();
    do_reset();
    core_out_en = 4'b1110;
    for (int p = 0; p < 4; p++) send_pkt(p, 3);
    repeat (36) @(negedge clk);
    vectors++; if (out_cnt !== 0) begin errors++; $display("FAIL t2_idle_cnt: got %0d want 0", out_cnt); end
    vectors++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL t2_idle_valid: got %b want 0", m_tvalid); end
    vectors++; if (busy !== 1'b1) begin errors++; $display("FAIL t2_busy: got %b want 1", busy); end
    core_out_en = '1;
    wait_out(12);
    repeat (5) @(negedge clk);
    for (int k = 0; k < 12; k++) begin
      vectors++; if (out_log[k] !== exp_word(k / 3, k % 3, 3)) begin errors++; $display("FAIL t2_out beat %0d: got %h want %h", k, out_log[k], exp_word(k / 3, k % 3, 3)); end
    end
    vectors++; if (out_cnt !== 12) begin errors++; $display("FAIL t2_out_cnt: got %0d want 12", out_cnt); end
  endtask

  task automatic test_inflight_limit();
    do_reset();
    m_tready = 1'b0;
    for (int p = 0; p < 8; p++) send_pkt(p, 2);
    drive_beat(8, 0, 2);
    repeat (5) @(negedge clk);
    vectors++; if (s_tready !== 1'b0) begin errors++; $display("FAIL t3_full_ready: got %b want 0", s_tready); end
    vectors++; if (c_in_tvalid !== 4'b0000) begin errors++; $display("FAIL t3_full_cvalid: got %b want 0000", c_in_tvalid); end
    vectors++; if (stat_pkts_in !== 32'd8) begin errors++; $display("FAIL t3_stat_in8: got %0d want 8", stat_pkts_in); end
    m_tready = 1'b1;
    send_pkt(8, 2);
    wait_out(18);
    repeat (5) @(negedge clk);
    vectors++; if (core_log[8] !== 0) begin errors++; $display("FAIL t3_p8_core: got %0d want 0", core_log[8]); end
    for (int k = 0; k < 18; k++) begin
      vectors++; if (out_log[k] !== exp_word(k / 2, k % 2, 2)) begin errors++; $display("FAIL t3_out beat %0d: got %h want %h", k, out_log[k], exp_word(k / 2, k % 2, 2)); end
    end
    vectors++; if (stat_pkts_out !== 32'd9) begin errors++; $display("FAIL t3_stat_out: got %0d want 9", stat_pkts_out); end
  endtask

  task automatic test_core_enable();
    do_reset();
    core_en = 4'b0101;
    for (int p = 0; p < 4; p++) send_pkt(p, 1);
    wait_out(4);
    for (int p = 0; p < 4; p++) begin
      vectors++; if (core_log[p] !== ((p % 2) * 2)) begin errors++; $display("FAIL t4_core pkt %0d: got %0d want %0d", p, core_log[p], (p % 2) * 2); end
    end
    core_en = 4'b0000;
    drive_beat(4, 0, 1);
    repeat (5) @(negedge clk);
    vectors++; if (s_tready !== 1'b0) begin errors++; $display("FAIL t4_dis_ready: got %b want 0", s_tready); end
    vectors++; if (c_in_tvalid !== 4'b0000) begin errors++; $display("FAIL t4_dis_cvalid: got %b want 0000", c_in_tvalid); end
    core_en = 4'b0010;
    send_pkt(4, 1);
    wait_out(5);
    vectors++; if (core_log[4] !== 1) begin errors++; $display("FAIL t4_reen_core: got %0d want 1", core_log[4]); end
    for (int k = 0; k < 5; k++) begin
      vectors++; if (out_log[k] !== exp_word(k, 0, 1)) begin errors++; $display("FAIL t4_out beat %0d: got %h want %h", k, out_log[k], exp_word(k, 0, 1)); end
    end
    core_en = '1;
  endtask

  task automatic test_disable_mid_packet();
    do_reset();
    core_out_en = 4'b1110;
    send_pkt(0, 1);
    fork
      send_pkt(1, 3);
      begin
        int w;
        w = 0;
        while (in_cnt < 2 && w < 100) begin
          @(negedge clk);
          w++;
        end
        core_en = 4'b0000;
      end
    join
    repeat (10) @(negedge clk);
    vectors++; if (in_beats[1] !== 3) begin errors++; $display("FAIL t5_core1_beats: got %0d want 3", in_beats[1]); end
    vectors++; if (core_log[1] !== 1) begin errors++; $display("FAIL t5_core: got %0d want 1", core_log[1]); end
    vectors++; if (out_cnt !== 0) begin errors++; $display("FAIL t5_held: got %0d want 0", out_cnt); end
    core_out_en = '1;
    wait_out(4);
    vectors++; if (out_log[0] !== exp_word(0, 0, 1)) begin errors++; $display("FAIL t5_out beat 0: got %h want %h", out_log[0], exp_word(0, 0, 1)); end
    for (int k = 0; k < 3; k++) begin
      vectors++; if (out_log[k+1] !== exp_word(1, k, 3)) begin errors++; $display("FAIL t5_out beat %0d: got %h want %h", k + 1, out_log[k+1], exp_word(1, k, 3)); end
    end
    core_en = '1;
  endtask

  task automatic test_reset_mid_packet();
    do_reset();
    send_pkt(0, 1);
    drive_beat(1, 0, 3);
    vectors++; if (c_in_tvalid !== 4'b0010) begin errors++; $display("FAIL t6_route: got %b want 0010", c_in_tvalid); end
    @(negedge clk);
    drive_beat(1, 1, 3);
    vectors++; if (busy !== 1'b1) begin errors++; $display("FAIL t6_busy_mid: got %b want 1", busy); end
    rst_n = 1'b0;
    s_tvalid = 1'b0;
    @(negedge clk);
    vectors++; if (s_tready !== 1'b0) begin errors++; $display("FAIL t6_rst_ready: got %b want 0", s_tready); end
    vectors++; if (c_out_tready !== 4'b0000) begin errors++; $display("FAIL t6_rst_cout: got %b want 0000", c_out_tready); end
    vectors++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL t6_rst_mvalid: got %b want 0", m_tvalid); end
    vectors++; if (stat_pkts_in !== 32'd0) begin errors++; $display("FAIL t6_rst_stat_in: got %0d want 0", stat_pkts_in); end
    rst_n = 1'b1;
    @(negedge clk);
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL t6_post_busy: got %b want 0", busy); end
    send_pkt(0, 2);
    wait_out(2);
    repeat (3) @(negedge clk);
    vectors++; if (core_log[0] !== 0) begin errors++; $display("FAIL t6_core: got %0d want 0", core_log[0]); end
    for (int k = 0; k < 2; k++) begin
      vectors++; if (out_log[k] !== exp_word(0, k, 2)) begin errors++; $display("FAIL t6_out beat %0d: got %h want %h", k, out_log[k], exp_word(0, k, 2)); end
    end
    vectors++; if (stat_pkts_in !== 32'd1) begin errors++; $display("FAIL t6_stat_in: got %0d want 1", stat_pkts_in); end
    vectors++; if (stat_pkts_out !== 32'd1) begin errors++; $display("FAIL t6_stat_out: got %0d want 1", stat_pkts_out); end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_round_robin();
    test_head_blocking();
    test_inflight_limit();
    test_core_enable();
    test_disable_mid_packet();
    test_reset_mid_packet();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
